// File: rtl/cond_flag_register.sv
// cond_flag_register
//   Holds the architectural condition flags {N, Z, C, V} and feeds them to the
//   conditional_check stage. Flags are written from the ALU only when the
//   instruction's condition passes and the matching flag-write group is set.
//   Also gates the decoder's PC/register/memory write strobes with condEx and
//   keeps a registered copy of condEx for the multicycle write-back step.
//
// Ports
//   clk           in   system clock, rising-edge active
//   rst           in   asynchronous reset, active-low
//   en            in   stage advance (0 = stall, all registers hold)
//   aluFlags[3:0] in   ALU result flags {N, Z, C, V}
//   flagW[1:0]    in   flag-write groups: [1] = N,Z ; [0] = C,V
//   condEx        in   condition-pass result from conditional_check
//   pcs           in   decoder PC-write request
//   regW          in   decoder register-write request
//   memW          in   decoder memory-write request
//   noWrite       in   compare-class instruction, suppresses register write
//   negative      out  stored N flag
//   zero          out  stored Z flag
//   cout          out  stored C flag
//   overflow      out  stored V flag
//   pcSrc         out  gated PC write
//   regWrite      out  gated register write
//   memWrite      out  gated memory write
//   condExDelayed out  condEx captured on the last enabled edge
//   flagsUpd      out  one-cycle pulse after any flag group was written
module cond_flag_register #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] aluFlags,
  input  logic [1:0] flagW,
  input  logic       condEx,
  input  logic       pcs,
  input  logic       regW,
  input  logic       memW,
  input  logic       noWrite,
  output logic       negative,
  output logic       zero,
  output logic       cout,
  output logic       overflow,
  output logic       pcSrc,
  output logic       regWrite,
  output logic       memWrite,
  output logic       condExDelayed,
  output logic       flagsUpd
);

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic       wr_nz;
  logic       wr_cv;
  logic       cond_q;
  logic       upd_q;

  always_comb begin
    wr_nz = en & condEx & flagW[1];
    wr_cv = en & condEx & flagW[0];
  end

  // The group enables are used as if-conditions so that an X on aluFlags
  // cannot reach the stored flags when no write is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nz_q <= RESET_FLAGS[3:2];
      cv_q <= RESET_FLAGS[1:0];
    end else begin
      if (wr_nz) nz_q <= aluFlags[3:2];
      if (wr_cv) cv_q <= aluFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cond_q <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      if (en) cond_q <= condEx;
      upd_q <= wr_nz | wr_cv;
    end
  end

  // Strobes ignore en (the consumer honours its own stall) but are forced
  // low while reset is asserted.
  always_comb begin
    pcSrc    = rst & pcs  & condEx;
    regWrite = rst & regW & condEx & ~noWrite;
    memWrite = rst & memW & condEx;
  end

  assign negative      = nz_q[1];
  assign zero          = nz_q[0];
  assign cout          = cv_q[1];
  assign overflow      = cv_q[0];
  assign condExDelayed = cond_q;
  assign flagsUpd      = upd_q;

endmodule

// File: tb/tb_cond_flag_register.sv
module tb_cond_flag_register;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] aluFlags;
  logic [1:0] flagW;
  logic       condEx;
  logic       pcs;
  logic       regW;
  logic       memW;
  logic       noWrite;
  logic       negative;
  logic       zero;
  logic       cout;
  logic       overflow;
  logic       pcSrc;
  logic       regWrite;
  logic       memWrite;
  logic       condExDelayed;
  logic       flagsUpd;

  int unsigned n_checks;
  int unsigned n_fail;

  cond_flag_register #(.RESET_FLAGS(4'b0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .aluFlags      (aluFlags),
    .flagW         (flagW),
    .condEx        (condEx),
    .pcs           (pcs),
    .regW          (regW),
    .memW          (memW),
    .noWrite       (noWrite),
    .negative      (negative),
    .zero          (zero),
    .cout          (cout),
    .overflow      (overflow),
    .pcSrc         (pcSrc),
    .regWrite      (regWrite),
    .memWrite      (memWrite),
    .condExDelayed (condExDelayed),
    .flagsUpd      (flagsUpd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags();
    return {negative, zero, cout, overflow};
  endfunction

  function automatic logic [3:0] strobes();
    return {1'b0, pcSrc, regWrite, memWrite};
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held with every write-enabling input active.
    rst = 1'b0; en = 1'b1; aluFlags = 4'b1111; flagW = 2'b11; condEx = 1'b1;
    pcs = 1'b1; regW = 1'b1; memW = 1'b1; noWrite = 1'b0;
    tick(); tick();
    check("reset_flags",   flags(), 4'b0000);
    check("reset_strobes", strobes(), 4'b0000);
    check("reset_upd",     {3'b0, flagsUpd}, 4'b0);
    check("reset_cdly",    {3'b0, condExDelayed}, 4'b0);

    // Release between edges: flags unchanged until the next edge.
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("release_flags", flags(), 4'b0000);
    check("release_strobes", strobes(), 4'b0111);

    // Full write.
    aluFlags = 4'b0110; flagW = 2'b11; condEx = 1'b1;
    tick();
    check("full_write_flags", flags(), 4'b0110);
    check("full_write_upd",   {3'b0, flagsUpd}, 4'b1);
    check("full_write_cdly",  {3'b0, condExDelayed}, 4'b1);

    // No write; aluFlags X must not leak in.
    flagW = 2'b00; aluFlags = 4'bxxxx;
    tick();
    check("hold_flags", flags(), 4'b0110);
    check("hold_upd",   {3'b0, flagsUpd}, 4'b0);

    // Group isolation.
    flagW = 2'b01; aluFlags = 4'b1001;
    tick();
    check("cv_only_flags", flags(), 4'b0101);
    check("cv_only_upd",   {3'b0, flagsUpd}, 4'b1);
    flagW = 2'b10; aluFlags = 4'b1000;
    tick();
    check("nz_only_flags", flags(), 4'b1001);

    // Condition fail: no write, strobes all low.
    condEx = 1'b0; flagW = 2'b11; aluFlags = 4'b1111;
    pcs = 1'b1; regW = 1'b1; memW = 1'b1; noWrite = 1'b0;
    #1;
    check("condfail_strobes", strobes(), 4'b0000);
    tick();
    check("condfail_flags", flags(), 4'b1001);
    check("condfail_upd",   {3'b0, flagsUpd}, 4'b0);
    check("condfail_cdly",  {3'b0, condExDelayed}, 4'b0);

    // Stall with a passing condition: nothing written, condExDelayed holds.
    en = 1'b0; condEx = 1'b1; flagW = 2'b11; aluFlags = 4'b0110;
    #1;
    check("stall_strobes", strobes(), 4'b0111);
    tick();
    check("stall_flags", flags(), 4'b1001);
    check("stall_cdly",  {3'b0, condExDelayed}, 4'b0);
    check("stall_upd",   {3'b0, flagsUpd}, 4'b0);

    // Gating: noWrite suppresses only the register write.
    en = 1'b1; flagW = 2'b00; condEx = 1'b1;
    pcs = 1'b1; regW = 1'b1; memW = 1'b1; noWrite = 1'b1;
    #1;
    check("nowrite_strobes", strobes(), 4'b0101);
    noWrite = 1'b0; pcs = 1'b0;
    #1;
    check("regw_only_strobes", strobes(), 4'b0011);
    pcs = 1'b1;
    tick();
    check("cdly_loaded", {3'b0, condExDelayed}, 4'b1);
    condEx = 1'b0;
    #1;
    check("cdly_after_toggle", {3'b0, condExDelayed}, 4'b1);
    check("toggle_strobes",    strobes(), 4'b0000);
    tick();
    check("cdly_cleared", {3'b0, condExDelayed}, 4'b0);

    // Set all flags, then reset asynchronously with a write pending.
    condEx = 1'b1; flagW = 2'b11; aluFlags = 4'b1111;
    tick();
    check("all_ones_flags", flags(), 4'b1111);
    aluFlags = 4'b0101;
    #2 rst = 1'b0;
    #1;
    check("async_rst_flags",   flags(), 4'b0000);
    check("async_rst_strobes", strobes(), 4'b0000);
    check("async_rst_upd",     {3'b0, flagsUpd}, 4'b0);
    tick();
    check("async_rst_write_lost", flags(), 4'b0000);
    check("async_rst_cdly",       {3'b0, condExDelayed}, 4'b0);

    rst = 1'b1;
    tick();
    check("post_rst_write", flags(), 4'b0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
